// File: rtl/aqp_ebus_io_target_pkg.sv
// rtl/aqp_ebus_io_target_pkg.sv - shared ebus target state encoding, idle byte and port decode helper
package aqp_ebus_io_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_WAIT_END
  } ebus_state_t;

  localparam logic [7:0] EBUS_IDLE_BYTE = 8'hFF;

  function automatic logic port_match(input logic [7:0] a, input logic [7:0] base,
                                      input logic [7:0] mask);
    return (a & mask) == base;
  endfunction

endpackage

// File: rtl/aqp_ebus_io_target_if.sv
// rtl/aqp_ebus_io_target_if.sv - register backend request/response handshake
interface aqp_ebus_io_target_if #(
  parameter int ADDR_W = 4
) ();
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wrdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_rddata;

  modport master (
    output req_valid, req_wr, req_addr, req_wrdata,
    input  req_ready, rsp_valid, rsp_rddata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wrdata,
    output req_ready, rsp_valid, rsp_rddata
  );
endinterface

// File: rtl/aqp_ebus_io_target_strobe_sync.sv
// rtl/aqp_ebus_io_target_strobe_sync.sv - 3-flop synchronizer with selectable falling-edge tap
module aqp_ebus_io_target_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic fast_sync,
  input  logic strobe_n,
  output logic fall,
  output logic level
);
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b111;
    else        sync <= {sync[1:0], strobe_n};
  end

  // T80 strobes are already clk-aligned, so the earlier tap saves a cycle
  assign fall  = fast_sync ? (sync[1] & ~sync[0]) : (sync[2] & ~sync[1]);
  assign level = fast_sync ? sync[0] : sync[1];
endmodule

// File: rtl/aqp_ebus_io_target.sv
// rtl/aqp_ebus_io_target.sv - Z80 IORQ responder turning decoded bus cycles into backend requests
module aqp_ebus_io_target
  import aqp_ebus_io_target_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'hE0,
  parameter logic [7:0] BASE_MASK = 8'hF0,
  parameter int         ADDR_W    = 4,
  parameter int         TIMEOUT   = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fast_sync,
  input  logic [7:0]           ebus_a,
  input  logic [7:0]           ebus_d_in,
  input  logic                 ebus_rd_n,
  input  logic                 ebus_wr_n,
  input  logic                 ebus_iorq_n,
  input  logic                 ebus_mreq_n,
  output logic [7:0]           ebus_d_out,
  output logic                 ebus_d_oe,
  aqp_ebus_io_target_if.master be,
  output logic                 timeout_err,
  output logic                 overrun_err
);
  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  ebus_state_t      state, state_next;
  logic             rd_fall, rd_level, wr_fall, wr_level;
  logic             decoded, rd_hit, wr_hit, active_level;
  logic             start, accept, capture, timeout_hit, overrun;
  logic             read_active;
  logic [CNT_W-1:0] cnt, cnt_inc;

  aqp_ebus_io_target_strobe_sync u_rd_sync (
    .clk(clk), .rst_n(reset_n), .fast_sync(fast_sync),
    .strobe_n(ebus_rd_n), .fall(rd_fall), .level(rd_level)
  );

  aqp_ebus_io_target_strobe_sync u_wr_sync (
    .clk(clk), .rst_n(reset_n), .fast_sync(fast_sync),
    .strobe_n(ebus_wr_n), .fall(wr_fall), .level(wr_level)
  );

  assign decoded      = !ebus_iorq_n && ebus_mreq_n && port_match(ebus_a, BASE_PORT, BASE_MASK);
  assign rd_hit       = rd_fall && decoded;
  assign wr_hit       = wr_fall && decoded && !rd_fall;
  assign cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign active_level = be.req_wr ? wr_level : rd_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    overrun     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_hit || wr_hit) begin
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (be.req_ready) begin
          accept     = 1'b1;
          state_next = be.req_wr ? ST_WAIT_END : ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (be.rsp_valid) begin
          capture    = 1'b1;
          state_next = ST_WAIT_END;
        end else if (cnt_inc == CNT_MAX) begin
          timeout_hit = 1'b1;
          state_next  = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (active_level) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE && (rd_hit || wr_hit)) overrun = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ebus_d_out    <= EBUS_IDLE_BYTE;
      read_active   <= 1'b0;
      be.req_valid  <= 1'b0;
      be.req_wr     <= 1'b0;
      be.req_addr   <= '0;
      be.req_wrdata <= '0;
      cnt           <= '0;
      timeout_err   <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      overrun_err <= overrun;
      // The strobe cycle itself counts as the first timeout tick
      if (start) begin
        be.req_valid  <= 1'b1;
        be.req_wr     <= wr_hit;
        be.req_addr   <= ebus_a[ADDR_W-1:0];
        be.req_wrdata <= ebus_d_in;
        cnt           <= CNT_W'(1);
        if (rd_hit) begin
          ebus_d_out  <= EBUS_IDLE_BYTE;
          read_active <= 1'b1;
        end
      end else begin
        cnt <= cnt_inc;
      end
      if (accept)  be.req_valid <= 1'b0;
      if (capture) ebus_d_out   <= be.rsp_rddata;
      if (state != ST_IDLE && state_next == ST_IDLE) read_active <= 1'b0;
    end
  end

  // Raw RD# lets the bus driver release the instant the Z80 ends the cycle
  assign ebus_d_oe = read_active && !ebus_rd_n;
endmodule
